alu_serial_ctrl: RTL and testbench

//  Bit-serial sequencer wrapped around one combinational 1-bit ALU slice: it feeds the slice one
//  bit position per cycle and consumes its result and carry-out. Carry-out is registered and fed

---
 rtl/alu_serial_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_alu_serial_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_serial_ctrl.sv
// Bit-serial sequencer around an external combinational 1-bit ALU slice.
// One bit position per cycle, LSB first. The slice carry-out is registered
// and fed back as the next carry-in. SLT takes one extra fix-up cycle on bit 0.
module alu_serial_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic [3:0]       alu_ctrl_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             cout_o,
  output logic             overflow_o,
  output logic             slice_src1_o,
  output logic             slice_src2_o,
  output logic             slice_less_o,
  output logic             slice_A_invert_o,
  output logic             slice_B_invert_o,
  output logic             slice_cin_o,
  output logic [1:0]       slice_operation_o,
  input  logic             slice_result_i,
  input  logic             slice_cout_i
);

  localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_SLT_FIX,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [IW-1:0]    idx_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] res_q, res_d;
  logic             a_inv_q, b_inv_q;
  logic [1:0]       op_q;
  logic             is_arith_q, is_slt_q;
  logic             set_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q, cout_q, ovf_q;

  logic             dec_a_inv, dec_b_inv, dec_cin, dec_arith, dec_slt;
  logic [1:0]       dec_op;
  logic             last_bit;
  logic             ovf_now;

  assign last_bit   = (idx_q == IW'(WIDTH - 1));
  assign ovf_now    = carry_q ^ slice_cout_i;
  assign busy_o     = (state_q != S_IDLE);
  assign done_o     = (state_q == S_DONE);
  assign result_o   = result_q;
  assign zero_o     = zero_q;
  assign cout_o     = cout_q;
  assign overflow_o = ovf_q;

  // Decode the ALU control code into slice controls; unknown codes act as AND.
  always_comb begin
    dec_a_inv = 1'b0;
    dec_b_inv = 1'b0;
    dec_cin   = 1'b0;
    dec_arith = 1'b0;
    dec_slt   = 1'b0;
    dec_op    = 2'b00;
    case (alu_ctrl_i)
      4'b0001: dec_op = 2'b01;
      4'b0010: begin
        dec_op    = 2'b10;
        dec_arith = 1'b1;
      end
      4'b0110: begin
        dec_op    = 2'b10;
        dec_b_inv = 1'b1;
        dec_cin   = 1'b1;
        dec_arith = 1'b1;
      end
      4'b0111: begin
        dec_op    = 2'b10;
        dec_b_inv = 1'b1;
        dec_cin   = 1'b1;
        dec_slt   = 1'b1;
      end
      4'b1100: begin
        dec_a_inv = 1'b1;
        dec_b_inv = 1'b1;
      end
      default: dec_op = 2'b00;
    endcase
  end

  // Working result with the current bit position merged in from the slice.
  always_comb begin
    res_d        = res_q;
    res_d[idx_q] = slice_result_i;
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic and slice drive; slice inputs are quiet outside RUN/SLT_FIX.
  always_comb begin
    state_d           = state_q;
    slice_src1_o      = 1'b0;
    slice_src2_o      = 1'b0;
    slice_less_o      = 1'b0;
    slice_A_invert_o  = 1'b0;
    slice_B_invert_o  = 1'b0;
    slice_cin_o       = 1'b0;
    slice_operation_o = 2'b00;
    case (state_q)
      S_IDLE: begin
        if (start_i) state_d = S_RUN;
      end
      S_RUN: begin
        slice_src1_o      = a_q[idx_q];
        slice_src2_o      = b_q[idx_q];
        slice_A_invert_o  = a_inv_q;
        slice_B_invert_o  = b_inv_q;
        slice_cin_o       = carry_q;
        slice_operation_o = op_q;
        if (last_bit) state_d = is_slt_q ? S_SLT_FIX : S_DONE;
      end
      S_SLT_FIX: begin
        slice_src1_o      = a_q[0];
        slice_src2_o      = b_q[0];
        slice_less_o      = set_q;
        slice_B_invert_o  = 1'b1;
        slice_cin_o       = 1'b1;
        slice_operation_o = 2'b11;
        state_d           = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Operand capture, serial accumulation and result/flag registers.
  // Visible result and flags load on the edge into DONE so they are valid with done_o.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx_q      <= '0;
      carry_q    <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      res_q      <= '0;
      a_inv_q    <= 1'b0;
      b_inv_q    <= 1'b0;
      op_q       <= 2'b00;
      is_arith_q <= 1'b0;
      is_slt_q   <= 1'b0;
      set_q      <= 1'b0;
      result_q   <= '0;
      zero_q     <= 1'b0;
      cout_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            a_q        <= src1_i;
            b_q        <= src2_i;
            a_inv_q    <= dec_a_inv;
            b_inv_q    <= dec_b_inv;
            op_q       <= dec_op;
            is_arith_q <= dec_arith;
            is_slt_q   <= dec_slt;
            idx_q      <= '0;
            carry_q    <= dec_cin;
          end
        end
        S_RUN: begin
          res_q   <= res_d;
          carry_q <= slice_cout_i;
          idx_q   <= idx_q + IW'(1);
          if (last_bit) begin
            set_q <= slice_result_i ^ ovf_now;
            if (!is_slt_q) begin
              result_q <= res_d;
              zero_q   <= (res_d == '0);
              cout_q   <= is_arith_q & slice_cout_i;
              ovf_q    <= is_arith_q & ovf_now;
            end
          end
        end
        S_SLT_FIX: begin
          result_q <= {{(WIDTH-1){1'b0}}, slice_result_i};
          zero_q   <= ~slice_result_i;
          cout_q   <= 1'b0;
          ovf_q    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Self-checking bench: behavioural 1-bit slice plus word-level reference model.
module tb_alu_serial_ctrl;

  localparam int unsigned W = 32;

  localparam logic [3:0] C_AND = 4'b0000;
  localparam logic [3:0] C_OR  = 4'b0001;
  localparam logic [3:0] C_ADD = 4'b0010;
  localparam logic [3:0] C_SUB = 4'b0110;
  localparam logic [3:0] C_SLT = 4'b0111;
  localparam logic [3:0] C_NOR = 4'b1100;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] src1 = '0, src2 = '0;
  logic [3:0]   ctrl = '0;
  logic         busy, done, zero, cout, ovf;
  logic [W-1:0] result;
  logic         s_a, s_b, s_less, s_ainv, s_binv, s_cin;
  logic [1:0]   s_op;
  logic         s_res, s_cout;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  always #5 clk = ~clk;

  alu_serial_ctrl #(.WIDTH(W)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .src1_i(src1), .src2_i(src2), .alu_ctrl_i(ctrl),
    .busy_o(busy), .done_o(done), .result_o(result),
    .zero_o(zero), .cout_o(cout), .overflow_o(ovf),
    .slice_src1_o(s_a), .slice_src2_o(s_b), .slice_less_o(s_less),
    .slice_A_invert_o(s_ainv), .slice_B_invert_o(s_binv),
    .slice_cin_o(s_cin), .slice_operation_o(s_op),
    .slice_result_i(s_res), .slice_cout_i(s_cout)
  );

  // Classic 1-bit ALU slice: optional input inversion, full adder, less pass-through.
  always_comb begin
    logic a, b;
    a      = s_a ^ s_ainv;
    b      = s_b ^ s_binv;
    s_cout = (a & b) | (a & s_cin) | (b & s_cin);
    case (s_op)
      2'b00:   s_res = a & b;
      2'b01:   s_res = a | b;
      2'b10:   s_res = a ^ b ^ s_cin;
      default: s_res = s_less;
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Word-level reference using signed/unsigned arithmetic.
  function automatic void model(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] r, output logic co, output logic ov);
    longint sa, sb, s, lo, hi;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    hi = (longint'(1) <<< (W - 1)) - 1;
    lo = -(longint'(1) <<< (W - 1));
    co = 1'b0;
    ov = 1'b0;
    case (c)
      C_OR:  r = a | b;
      C_NOR: r = ~(a | b);
      C_ADD: begin
        r  = a + b;
        co = ({1'b0, a} + {1'b0, b}) > {1'b0, {W{1'b1}}};
        s  = sa + sb;
        ov = (s > hi) || (s < lo);
      end
      C_SUB: begin
        r  = a - b;
        co = (a >= b);
        s  = sa - sb;
        ov = (s > hi) || (s < lo);
      end
      C_SLT: r = (sa < sb) ? W'(1) : W'(0);
      default: r = a & b;
    endcase
  endfunction

  function automatic logic [W+12:0] all_outs();
    return {busy, done, result, zero, cout, ovf, s_a, s_b, s_less, s_ainv, s_binv, s_cin, s_op};
  endfunction

  // One full operation from an IDLE cycle; checks latency, result, flags and handshake.
  task automatic run_op(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] er;
    logic ec, eo, seen;
    int unsigned k, lat;
    model(c, a, b, er, ec, eo);
    lat   = (c == C_SLT) ? W + 2 : W + 1;
    src1  = a;
    src2  = b;
    ctrl  = c;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_run", busy, 1);
    chk("cin_bit0", s_cin, (c == C_SUB || c == C_SLT) ? 1 : 0);
    seen = 1'b0;
    k    = 1;
    while (!seen && k <= W + 10) begin
      if (done) seen = 1'b1;
      else begin
        @(posedge clk); #1;
        k++;
      end
    end
    chk("done_seen", seen, 1);
    if (seen) begin
      chk("latency", k, lat);
      chk("result", result, er);
      chk("zero", zero, (er == '0) ? 1 : 0);
      chk("cout", cout, ec);
      chk("overflow", ovf, eo);
      chk("busy_done", busy, 1);
      chk("slice_quiet_done", {s_a, s_b, s_less, s_ainv, s_binv, s_cin, s_op}, 0);
    end
    @(posedge clk); #1;
    chk("done_pulse", done, 0);
    chk("busy_idle", busy, 0);
    chk("result_hold", result, er);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] er, a1, b1, a2, b2;
    logic ec, eo, seen;
    int unsigned k, g;
    logic [3:0] codes [6];
    logic [W-1:0] corners [6];
    codes   = '{C_AND, C_OR, C_ADD, C_SUB, C_SLT, C_NOR};
    corners = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h5};

    #1;
    chk("reset_outputs", all_outs(), 0);
    #20;
    rst = 1'b0;
    @(posedge clk); #1;

    // Reset during an ADD aborts it with no done pulse.
    run_op(C_ADD, 32'd5, 32'd3);
    src1 = 32'd5; src2 = 32'd3; ctrl = C_ADD; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midop_reset_outputs", all_outs(), 0);
    @(posedge clk); #2;
    rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    chk("no_done_after_reset", seen, 0);
    run_op(C_ADD, 32'd5, 32'd3);

    // Directed corner cases.
    run_op(C_ADD, 32'h7FFF_FFFF, 32'h1);
    run_op(C_SUB, 32'd5, 32'd5);
    run_op(C_SUB, 32'd0, 32'd1);
    run_op(C_SLT, 32'hFFFF_FFFF, 32'h1);
    run_op(C_SLT, 32'h7FFF_FFFF, 32'h8000_0000);
    run_op(C_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    run_op(C_OR,  32'hF0F0_F0F0, 32'h0FF0_0FF0);
    run_op(C_NOR, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    run_op(4'b1111, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    run_op(C_ADD, 32'hFFFF_FFFF, 32'h1);

    // start held high: second op only accepted in the cycle after DONE.
    a1 = 32'h1234_5678; b1 = 32'h1111_1111;
    a2 = 32'h0000_0010; b2 = 32'h0000_0020;
    src1 = a1; src2 = b1; ctrl = C_ADD; start = 1'b1;
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    #1;
    src1 = a2; src2 = b2; ctrl = C_SUB;
    seen = 1'b0;
    k = 4;
    while (!seen && k <= W + 10) begin
      if (done) seen = 1'b1;
      else begin
        @(posedge clk); #1;
        k++;
      end
    end
    chk("b2b_done1_seen", seen, 1);
    chk("b2b_latency1", k, W + 1);
    chk("b2b_result1", result, a1 + b1);
    seen = 1'b0;
    g = 0;
    while (!seen && g <= W + 10) begin
      @(posedge clk); #1;
      g++;
      if (g == 1) chk("b2b_idle_gap", busy, 0);
      if (g == 2) chk("b2b_reaccept", busy, 1);
      if (g == 4) start = 1'b0;
      if (done) seen = 1'b1;
    end
    model(C_SUB, a2, b2, er, ec, eo);
    chk("b2b_done2_seen", seen, 1);
    chk("b2b_gap", g, W + 2);
    chk("b2b_result2", result, er);
    chk("b2b_cout2", cout, ec);
    @(posedge clk); #1;
    chk("b2b_stop", busy, 0);

    // Randomized operations.
    for (int i = 0; i < 40; i++) begin
      logic [3:0] c;
      logic [W-1:0] ra, rb;
      c  = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : codes[$urandom_range(0, 5)];
      ra = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : W'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : W'($urandom);
      run_op(c, ra, rb);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
